// File: rtl/vidac_scan.sv
// vidac_scan: display-side reader for the VIDAC video buffer.
// Scans a 320x200 8bpp image, doubled 2x2, into a 640x480@60 raster with
// top/bottom borders. One memory read per clock; all outputs are aligned
// three clocks after the internal counter state that produced them.
//
// Ports:
//   clock  - pixel clock (25 MHz)
//   reset  - asynchronous, active-high
//   base   - video-memory start offset, sampled at frame start (hc=0, vc=0)
//   a      - video-memory read address (byte offset in the A0000h window)
//   i      - read data, valid the clock after a is presented
//   pixel  - pixel index to the palette/DAC
//   de     - display enable (visible area)
//   hs, vs - horizontal / vertical sync, active low
//   frame  - one-clock pulse at the start of each frame
module vidac_scan #(
    parameter int          H_VIS   = 640,
    parameter int          H_FP    = 16,
    parameter int          H_SYNC  = 96,
    parameter int          H_BP    = 48,
    parameter int          V_VIS   = 480,
    parameter int          V_FP    = 10,
    parameter int          V_SYNC  = 2,
    parameter int          V_BP    = 33,
    parameter int          IMG_TOP = 40,
    parameter int          IMG_W   = 320,
    parameter int          IMG_H   = 200,
    parameter logic [7:0]  BORDER  = 8'h00
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [16:0] base,
    output logic [16:0] a,
    input  logic [7:0]  i,
    output logic [7:0]  pixel,
    output logic        de,
    output logic        hs,
    output logic        vs,
    output logic        frame
);

    localparam int          H_TOT   = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int          V_TOT   = V_VIS + V_FP + V_SYNC + V_BP;
    localparam logic [9:0]  H_LAST  = 10'(H_TOT - 1);
    localparam logic [9:0]  V_LAST  = 10'(V_TOT - 1);
    localparam logic [9:0]  H_VIS_C = 10'(H_VIS);
    localparam logic [9:0]  V_VIS_C = 10'(V_VIS);
    localparam logic [9:0]  HS_ON   = 10'(H_VIS + H_FP);
    localparam logic [9:0]  HS_OFF  = 10'(H_VIS + H_FP + H_SYNC);
    localparam logic [9:0]  VS_ON   = 10'(V_VIS + V_FP);
    localparam logic [9:0]  VS_OFF  = 10'(V_VIS + V_FP + V_SYNC);
    localparam logic [9:0]  IMG_Y0  = 10'(IMG_TOP);
    localparam logic [9:0]  IMG_Y1  = 10'(IMG_TOP + 2 * IMG_H);
    localparam logic [16:0] IMG_W_C = 17'(IMG_W);

    logic [9:0]  r_hc;
    logic [9:0]  r_vc;
    // Row accumulator: holds the frame's latched base until the first row
    // step, so it also serves as the per-frame base register.
    logic [16:0] r_rowacc;
    logic [16:0] r_a;
    logic [7:0]  r_pixel;
    // Alignment pipelines: bit 0 = t+1, bit 1 = t+2, bit 2 = t+3 (output).
    logic [2:0]  r_de_p;
    logic [2:0]  r_hs_p;
    logic [2:0]  r_vs_p;
    logic [2:0]  r_frm_p;
    logic [2:0]  r_img_p;

    logic        w_hc_last;
    logic        w_vc_last;
    logic        w_img_line;
    logic        w_in_img;
    logic        w_odd_row;
    logic        w_de;
    logic        w_hs;
    logic        w_vs;
    logic        w_frame;
    logic [16:0] w_sx;
    logic [7:0]  w_pixel_nxt;

    assign w_hc_last  = (r_hc == H_LAST);
    assign w_vc_last  = (r_vc == V_LAST);
    assign w_img_line = (r_vc >= IMG_Y0) && (r_vc < IMG_Y1);
    assign w_in_img   = w_img_line && (r_hc < H_VIS_C);
    // Parity of (vc - IMG_TOP) without a subtractor.
    assign w_odd_row  = r_vc[0] ^ IMG_Y0[0];
    assign w_sx       = {8'd0, r_hc[9:1]};
    assign w_de       = (r_hc < H_VIS_C) && (r_vc < V_VIS_C);
    assign w_hs       = !((r_hc >= HS_ON) && (r_hc < HS_OFF));
    assign w_vs       = !((r_vc >= VS_ON) && (r_vc < VS_OFF));
    assign w_frame    = (r_hc == 10'd0) && (r_vc == 10'd0);

    // Horizontal and vertical raster counters.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_hc <= 10'd0;
            r_vc <= 10'd0;
        end else if (w_hc_last) begin
            r_hc <= 10'd0;
            r_vc <= w_vc_last ? 10'd0 : (r_vc + 10'd1);
        end else begin
            r_hc <= r_hc + 10'd1;
        end
    end

    // Row accumulator: load base at frame start, step one source row after
    // every second image line (replaces sy*IMG_W).
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_rowacc <= 17'd0;
        end else if (w_frame) begin
            r_rowacc <= base;
        end else if (w_hc_last && w_img_line && w_odd_row) begin
            r_rowacc <= r_rowacc + IMG_W_C;
        end else begin
            r_rowacc <= r_rowacc;
        end
    end

    // Read address: each source byte is read on two consecutive clocks;
    // outside the image the last address is held.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_a <= 17'd0;
        end else if (w_in_img) begin
            r_a <= r_rowacc + w_sx;
        end else begin
            r_a <= r_a;
        end
    end

    // Timing/flag delay lines matching the address-to-data latency.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_de_p  <= 3'b000;
            r_hs_p  <= 3'b111;
            r_vs_p  <= 3'b111;
            r_frm_p <= 3'b000;
            r_img_p <= 3'b000;
        end else begin
            r_de_p  <= {r_de_p[1:0],  w_de};
            r_hs_p  <= {r_hs_p[1:0],  w_hs};
            r_vs_p  <= {r_vs_p[1:0],  w_vs};
            r_frm_p <= {r_frm_p[1:0], w_frame};
            r_img_p <= {r_img_p[1:0], w_in_img};
        end
    end

    // Pixel select at t+2, when i belongs to the same counter state.
    always_comb begin
        w_pixel_nxt = 8'h00;
        if (r_de_p[1]) begin
            if (r_img_p[1]) begin
                w_pixel_nxt = i;
            end else begin
                w_pixel_nxt = BORDER;
            end
        end else begin
            w_pixel_nxt = 8'h00;
        end
    end

    // Output pixel register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_pixel <= 8'h00;
        end else begin
            r_pixel <= w_pixel_nxt;
        end
    end

    assign a     = r_a;
    assign pixel = r_pixel;
    assign de    = r_de_p[2];
    assign hs    = r_hs_p[2];
    assign vs    = r_vs_p[2];
    assign frame = r_frm_p[2];

endmodule

// File: tb/tb_vidac_scan.sv
// Testbench for vidac_scan with a shortened vertical geometry so that whole
// frames fit in a short run; horizontal timing is the full 800-clock line.
module tb_vidac_scan;

    localparam int H_VIS   = 640;
    localparam int H_FP    = 16;
    localparam int H_SYNC  = 96;
    localparam int H_BP    = 48;
    localparam int H_TOT   = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int V_VIS   = 12;
    localparam int V_FP    = 1;
    localparam int V_SYNC  = 2;
    localparam int V_BP    = 2;
    localparam int V_TOT   = V_VIS + V_FP + V_SYNC + V_BP;
    localparam int IMG_TOP = 2;
    localparam int IMG_W   = 320;
    localparam int IMG_H   = 4;
    localparam logic [7:0] BORDER = 8'h5A;
    localparam int FRAME   = H_TOT * V_TOT;

    logic        clock = 1'b0;
    logic        reset;
    logic [16:0] base;
    logic [16:0] a;
    logic [7:0]  i;
    logic [7:0]  pixel;
    logic        de;
    logic        hs;
    logic        vs;
    logic        frame;

    vidac_scan #(
        .H_VIS(H_VIS), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_VIS(V_VIS), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
        .IMG_TOP(IMG_TOP), .IMG_W(IMG_W), .IMG_H(IMG_H), .BORDER(BORDER)
    ) dut (
        .clock(clock), .reset(reset), .base(base), .a(a), .i(i),
        .pixel(pixel), .de(de), .hs(hs), .vs(vs), .frame(frame)
    );

    always #20 clock = ~clock;

    logic [7:0] mem [0:131071];

    // Synchronous read memory: data for address a appears the next clock.
    always @(posedge clock) i <= mem[a];

    typedef struct packed {
        logic [7:0] px;
        logic       de;
        logic       hs;
        logic       vs;
        logic       fr;
    } out_t;

    out_t        q[$];
    int          n_checks = 0;
    int          n_errors = 0;
    int          j;
    int          run;
    int unsigned fb;
    logic [16:0] exp_a;
    int          hs_low, vs_low, de_high;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h j=%0d run=%0d t=%0t", tag, got, exp, j, run, $time);
        end
    endtask

    task automatic start_run(input int r);
        out_t rst_e;
        rst_e = '{px: 8'h00, de: 1'b0, hs: 1'b1, vs: 1'b1, fr: 1'b0};
        run   = r;
        j     = 0;
        exp_a = 17'd0;
        fb    = 0;
        q.delete();
        repeat (3) q.push_back(rst_e);
        hs_low = 0; vs_low = 0; de_high = 0;
    endtask

    // Called right after negedge j: check outputs, then model counter state j.
    task automatic step();
        out_t e;
        out_t n;
        int   hc, vc, fno, p_hc, p_vc, p_fno, o_hc, o_vc, o_fno, addr;
        bit   img;

        e = q.pop_front();
        check_eq("pixel", 32'(pixel), 32'(e.px));
        check_eq("de",    32'(de),    32'(e.de));
        check_eq("hs",    32'(hs),    32'(e.hs));
        check_eq("vs",    32'(vs),    32'(e.vs));
        check_eq("frame", 32'(frame), 32'(e.fr));
        check_eq("a",     32'(a),     32'(exp_a));

        // Directed checks: a reflects state j-1, outputs reflect state j-3.
        if (j >= 1) begin
            p_hc = (j - 1) % H_TOT; p_vc = ((j - 1) / H_TOT) % V_TOT; p_fno = (j - 1) / FRAME;
            if (run == 0 && p_fno == 0 && p_vc == IMG_TOP && p_hc < 4)
                check_eq("a_line_top", 32'(a), 32'(p_hc / 2));
            if (run == 0 && p_fno == 0 && p_vc == IMG_TOP + 2 && p_hc == 0)
                check_eq("a_row1", 32'(a), 32'h140);
            if (run == 0 && p_fno == 1 && p_vc == IMG_TOP && p_hc == 0)
                check_eq("a_wrap_start", 32'(a), 32'h1FF00);
            if (run == 0 && p_fno == 1 && p_vc == IMG_TOP && p_hc == 510)
                check_eq("a_wrap_hi", 32'(a), 32'h1FFFF);
            if (run == 0 && p_fno == 1 && p_vc == IMG_TOP && p_hc == 512)
                check_eq("a_wrap_lo", 32'(a), 32'h00000);
            if (run == 1 && p_fno == 0 && p_vc == IMG_TOP && p_hc == 0)
                check_eq("a_new_base", 32'(a), 32'(fb));
        end
        if (j >= 3) begin
            o_hc = (j - 3) % H_TOT; o_vc = ((j - 3) / H_TOT) % V_TOT; o_fno = (j - 3) / FRAME;
            if (run == 0 && o_fno == 0 && o_vc == IMG_TOP && o_hc < 4)
                check_eq("px_line_top", 32'(pixel), 32'(o_hc / 2));
            if (run == 0 && o_fno == 0 && o_vc == IMG_TOP + 2 && o_hc == 0)
                check_eq("px_row1", 32'(pixel), 32'h40);
            if (run == 0 && j < 3 + FRAME) begin
                hs_low  += (hs == 1'b0) ? 1 : 0;
                vs_low  += (vs == 1'b0) ? 1 : 0;
                de_high += (de == 1'b1) ? 1 : 0;
            end
        end
        if (run == 0 && j == 3 + FRAME) begin
            check_eq("hs_low_clocks", 32'(hs_low),  32'(H_SYNC * V_TOT));
            check_eq("vs_low_clocks", 32'(vs_low),  32'(H_TOT * V_SYNC));
            check_eq("de_high_clocks", 32'(de_high), 32'(H_VIS * V_VIS));
        end

        // Stimulus for state j: base fixed in the first frame, forced to a
        // wrapping value for the second, random elsewhere (incl. mid-frame).
        hc = j % H_TOT; vc = (j / H_TOT) % V_TOT; fno = j / FRAME;
        if (hc == 0 && vc == 0) begin
            if (run == 0 && fno == 0)      base = 17'd0;
            else if (run == 0 && fno == 1) base = 17'h1FF00;
            else                           base = 17'($urandom);
            fb = int'(base);
        end else if (!(run == 0 && fno == 0) && $urandom_range(0, 999) == 0) begin
            base = 17'($urandom);
        end

        // Reference: direct source-coordinate arithmetic per counter state.
        img  = (hc < H_VIS) && (vc >= IMG_TOP) && (vc < IMG_TOP + 2 * IMG_H);
        addr = 0;
        if (img) addr = int'((fb + 32'((vc - IMG_TOP) / 2 * IMG_W) + 32'(hc / 2)) % 131072);
        n.de = (hc < H_VIS) && (vc < V_VIS);
        n.hs = !((hc >= H_VIS + H_FP) && (hc < H_VIS + H_FP + H_SYNC));
        n.vs = !((vc >= V_VIS + V_FP) && (vc < V_VIS + V_FP + V_SYNC));
        n.fr = (hc == 0) && (vc == 0);
        n.px = n.de ? (img ? mem[addr] : BORDER) : 8'h00;
        q.push_back(n);
        if (img) exp_a = 17'(addr);
        j++;
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_pixel"}, 32'(pixel), 32'h0);
        check_eq({tag, "_de"},    32'(de),    32'h0);
        check_eq({tag, "_hs"},    32'(hs),    32'h1);
        check_eq({tag, "_vs"},    32'(vs),    32'h1);
        check_eq({tag, "_frame"}, 32'(frame), 32'h0);
        check_eq({tag, "_a"},     32'(a),     32'h0);
    endtask

    initial begin
        reset = 1'b1;
        base  = 17'd0;
        run   = 0;
        j     = 0;
        for (int x = 0; x < 131072; x++) mem[x] = 8'(x);

        repeat (3) @(posedge clock);
        @(negedge clock);
        check_reset_outputs("rst0");
        reset = 1'b0;
        start_run(0);
        step();
        // Two full frames, then stop in the third at hc=300, vc=5.
        while (j < 2 * FRAME + 5 * H_TOT + 300) begin
            @(negedge clock);
            step();
        end
        @(negedge clock);
        #2 reset = 1'b1;
        #1 check_reset_outputs("rst_mid");
        repeat (3) @(posedge clock);
        @(negedge clock);
        check_reset_outputs("rst_hold");
        reset = 1'b0;
        start_run(1);
        step();
        while (j < FRAME + 12 * H_TOT) begin
            @(negedge clock);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
